// File: rtl/bank_fill_if.sv
// Bus between bank_fill_controller and its neighbours: memory read port,
// register-bank write port and the row handshake with the systolic array.
interface bank_fill_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [4*DATA_WIDTH-1:0] mem_rdata;
  logic                    bank_enable;
  logic [4*DATA_WIDTH-1:0] bank_data;
  logic [2:0]              bank_select;
  logic                    row_valid;
  logic                    row_ack;

  modport master (
    output mem_rd_en, mem_addr, bank_enable, bank_data, bank_select, row_valid,
    input  mem_rdata, row_ack
  );

  modport slave (
    input  mem_rd_en, mem_addr, bank_enable, bank_data, bank_select, row_valid,
    output mem_rdata, row_ack
  );
endinterface

// File: rtl/bank_fill_controller.sv
// Fetches two-word rows from memory into the 8-byte register bank, one row per
// handshake. Optional HOLD stall counter enabled by macro BANK_FILL_STALL_CNT_EN.
module bank_fill_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
`ifdef BANK_FILL_STALL_CNT_EN
  output logic [15:0]           stall_cycles,
`endif
  bank_fill_if.master           bus
);

  localparam int         BUS_W    = 4 * DATA_WIDTH;
  localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, WAIT_D, WR_LO, WR_HI, HOLD, FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            row_q, row_d;
  logic [BUS_W-1:0]      data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      data_q  <= data_d;
    end
  end

  // Read data arrives one cycle after each strobe, so the low word is
  // captured leaving RD_HI and the high word leaving WAIT_D.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          row_d   = '0;
          state_d = RD_LO;
        end
      end
      RD_LO:  state_d = RD_HI;
      RD_HI: begin
        data_d  = bus.mem_rdata;
        state_d = WAIT_D;
      end
      WAIT_D: begin
        data_d  = bus.mem_rdata;
        state_d = WR_LO;
      end
      WR_LO:  state_d = WR_HI;
      WR_HI:  state_d = HOLD;
      HOLD: begin
        if (bus.row_ack) begin
          addr_d = addr_q + ADDR_WIDTH'(2);
          if (row_q == LAST_ROW) begin
            state_d = FIN;
          end else begin
            row_d   = row_q + 8'd1;
            state_d = RD_LO;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank select trails bank_enable by one cycle to match the bank's sample stage.
  always_comb begin
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.bank_enable = 1'b0;
    bus.bank_select = 3'b111;
    bus.row_valid   = 1'b0;
    busy            = (state_q != IDLE);
    done            = 1'b0;
    case (state_q)
      RD_LO: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q;
      end
      RD_HI: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q + ADDR_WIDTH'(1);
      end
      WAIT_D: bus.bank_enable = 1'b1;
      WR_LO: begin
        bus.bank_enable = 1'b1;
        bus.bank_select = 3'b000;
      end
      WR_HI:   bus.bank_select = 3'b001;
      HOLD:    bus.row_valid   = 1'b1;
      FIN:     done            = 1'b1;
      default: ;
    endcase
  end

  assign bus.bank_data = data_q;

`ifdef BANK_FILL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == HOLD && !bus.row_ack && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_bank_fill_controller.sv
// Randomized bench for bank_fill_controller: row-timeline reference model,
// bank model and directed literal checks. Honours BANK_FILL_STALL_CNT_EN.
module tb_bank_fill_controller;

  localparam int NROWS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        busy;
  logic        done;
`ifdef BANK_FILL_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] mem [256];
  logic        st_en;
  logic [31:0] st_data;
  logic [63:0] bank;

  bank_fill_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  bank_fill_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_ROWS(NROWS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
`ifdef BANK_FILL_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    else               bus.mem_rdata <= $urandom();
  end

  // Register bank: one-cycle sample stage, commit selected by bank_select.
  always @(posedge clk) begin
    st_en   <= bus.bank_enable;
    st_data <= bus.bank_data;
    if (st_en && bus.bank_select == 3'b000) bank[31:0]  <= st_data;
    if (st_en && bus.bank_select == 3'b001) bank[63:32] <= st_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.row_valid && n < 40) begin
      tick();
      n++;
    end
    check("row_valid_seen", 64'(bus.row_valid), 64'(1));
  endtask

  task automatic finish_cmd();
    int n = 0;
    while (busy && n < 80) begin
      bus.row_ack = bus.row_valid;
      tick();
      n++;
    end
    bus.row_ack = 1'b0;
    check("finish_idle", 64'(busy), 64'(0));
  endtask

  // Reference model: position in the six-cycle row timeline (1..6 = c1..HOLD),
  // 0 = idle, 7 = done pulse.
  initial begin : model
    int          ph;
    int          mrow;
    logic [7:0]  ma, ma1;
    logic [15:0] mstall;
    logic [2:0]  exp_sel;
    ph = 0; mrow = 0; ma = '0; mstall = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ph = 0; mrow = 0; ma = '0; mstall = '0;
        check("rst_rd_en",   64'(bus.mem_rd_en),   64'(0));
        check("rst_addr",    64'(bus.mem_addr),    64'(0));
        check("rst_enable",  64'(bus.bank_enable), 64'(0));
        check("rst_data",    64'(bus.bank_data),   64'(0));
        check("rst_select",  64'(bus.bank_select), 64'(3'b111));
        check("rst_valid",   64'(bus.row_valid),   64'(0));
        check("rst_busy",    64'(busy),            64'(0));
        check("rst_done",    64'(done),            64'(0));
`ifdef BANK_FILL_STALL_CNT_EN
        check("rst_stall",   64'(stall_cycles),    64'(0));
`endif
      end else begin
        ma1 = ma + 8'd1;
        exp_sel = (ph == 4) ? 3'b000 : (ph == 5) ? 3'b001 : 3'b111;
        check("mem_rd_en", 64'(bus.mem_rd_en), 64'(ph == 1 || ph == 2));
        if (ph == 1) check("mem_addr_lo", 64'(bus.mem_addr), 64'(ma));
        if (ph == 2) check("mem_addr_hi", 64'(bus.mem_addr), 64'(ma1));
        check("bank_enable", 64'(bus.bank_enable), 64'(ph == 3 || ph == 4));
        check("bank_select", 64'(bus.bank_select), 64'(exp_sel));
        if (ph == 3) check("bank_data_lo", 64'(bus.bank_data), 64'(mem[ma]));
        if (ph >= 4 && ph <= 6) check("bank_data_hi", 64'(bus.bank_data), 64'(mem[ma1]));
        check("row_valid", 64'(bus.row_valid), 64'(ph == 6));
        if (ph == 6) check("bank_row", bank, {mem[ma1], mem[ma]});
        check("busy", 64'(busy), 64'(ph != 0));
        check("done", 64'(done), 64'(ph == 7));
`ifdef BANK_FILL_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(mstall));
`endif
        case (ph)
          0: if (start) begin
               ph = 1; ma = base_addr; mrow = 0; mstall = '0;
             end
          1, 2, 3, 4, 5: ph = ph + 1;
          6: if (bus.row_ack) begin
               ma = ma + 8'd2;
               if (mrow == NROWS - 1) ph = 7;
               else begin mrow++; ph = 1; end
             end else if (mstall != 16'hFFFF) begin
               mstall = mstall + 16'd1;
             end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; base_addr = '0; bus.row_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[8'h10] = 32'h03020100;
    mem[8'h11] = 32'h07060504;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic load with literal expectations, ack two cycles after row_valid.
    base_addr = 8'h10; start = 1'b1; tick(); start = 1'b0;
    check("basic_addr_10", 64'(bus.mem_addr), 64'h10);
    tick();
    check("basic_addr_11", 64'(bus.mem_addr), 64'h11);
    repeat (4) tick();
    check("basic_valid_c6", 64'(bus.row_valid), 64'(1));
    check("basic_bank", bank, 64'h0706050403020100);
    tick(); tick();
    check("basic_hold", 64'(bus.row_valid), 64'(1));
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    check("basic_row1_addr", 64'(bus.mem_addr), 64'h12);
    wait_valid(n);
    check("row_latency", 64'(n), 64'(5));
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    wait_valid(n);
    check("row_spacing", 64'(n + 1), 64'(6));
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    check("done_pulse", 64'(done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    tick();
    check("done_clear", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // Ignored start during RD_HI/HOLD and ignored ack during WR_LO.
    base_addr = 8'h40; start = 1'b1; tick(); start = 1'b0;
    tick();
    base_addr = 8'h80; start = 1'b1; tick(); start = 1'b0;
    check("no_restart", 64'(bus.mem_rd_en), 64'(0));
    tick();
    check("wr_lo_select", 64'(bus.bank_select), 64'(3'b000));
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    tick();
    check("ign_valid", 64'(bus.row_valid), 64'(1));
    start = 1'b1; tick(); start = 1'b0;
    check("ign_ack_hold", 64'(bus.row_valid), 64'(1));
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    check("ign_addr_42", 64'(bus.mem_addr), 64'h42);
    finish_cmd();

    // Address wrap.
    base_addr = 8'hFE; start = 1'b1; tick(); start = 1'b0;
    check("wrap_fe", 64'(bus.mem_addr), 64'hFE);
    tick();
    check("wrap_ff", 64'(bus.mem_addr), 64'hFF);
    wait_valid(n);
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    check("wrap_00", 64'(bus.mem_addr), 64'h00);
    tick();
    check("wrap_01", 64'(bus.mem_addr), 64'h01);
    finish_cmd();

    // Asynchronous reset in WAIT_D, then reload from a new base.
    base_addr = 8'h30; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("wait_d_enable", 64'(bus.bank_enable), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_busy",   64'(busy),            64'(0));
    check("async_enable", 64'(bus.bank_enable), 64'(0));
    check("async_select", 64'(bus.bank_select), 64'(3'b111));
    check("async_data",   64'(bus.bank_data),   64'(0));
    tick();
    reset = 1'b0; base_addr = 8'h50; start = 1'b1; tick(); start = 1'b0;
    check("reload_addr", 64'(bus.mem_addr), 64'h50);
    finish_cmd();

`ifdef BANK_FILL_STALL_CNT_EN
    base_addr = 8'h60; start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    repeat (5) tick();
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    wait_valid(n);
    repeat (3) tick();
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    wait_valid(n);
    bus.row_ack = 1'b1; tick(); bus.row_ack = 1'b0;
    check("stall_eight", 64'(stall_cycles), 64'(8));
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("stall_cleared", 64'(stall_cycles), 64'(0));
    finish_cmd();
`endif

    // Random traffic: stray starts/acks, wrap-prone bases, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      base_addr   = ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom());
      bus.row_ack = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    finish_cmd();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
